multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS-subset CPU: add, addi, addu, sub, subu, and, or, sll, lw, sw, beq, bne, bgtz, slt, sltu.
- Replaces the single-cycle combinational decoder when instruction and data share one memory port with a ready handshake.
- Drives PC/IR/register-file/ALU/memory strobes state by state, and counts retired instructions.
- Halts on an illegal opcode or a memory timeout.

Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles per memory access before trap; 1..255.
- RET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- equal  in  1  ALU zero flag.
- sign  in  1  ALU result sign.
- mem_ready  in  1  memory access complete this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write qualifier for mem_req.
- IorD  out  1  address select: 0=PC, 1=ALUOut.
- IRWr  out  1  load IR.
- PCWr  out  1  load PC.
- PCSrc  out  1  PC source: 0=ALU result, 1=ALUOut.
- RegWr  out  1  register-file write.
- RegDst  out  1  destination: 1=rd, 0=rt.
- MemToReg  out  1  write-back source: 1=MDR, 0=ALUOut.
- ALUSrcA  out  1  ALU A: 0=PC, 1=rs.
- ALUSrcB  out  2  ALU B: 00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2.
- ExtOp  out  1  1=sign-extend.
- ALUctr  out  3  0=and, 1=or, 2=add, 3=slt, 4=addu, 5=sll, 6=sub, 7=sltu.
- halted  out  1  sticky trap flag.
- err_code  out  2  trap cause: 0=none, 1=illegal, 2=timeout.
- retired  out  RET_W  count of completed instructions.

Behaviour:
- Reset: state=FETCH, wait counter=0, retired=0, halted=0, err_code=0.
- All strobes are 0 in any state that does not drive them; ALUctr and ALUSrcB default to 0.
- Outputs decode combinationally from state, except the PCWr/IRWr noted below.
- FETCH:
  - mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUctr=4.
  - On mem_ready: IRWr=1 and PCWr=1 (PC+4, PCSrc=0) in the same cycle, go to DECODE.
  - Otherwise hold.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUctr=2 (branch target into ALUOut).
  - Dispatch on op/funct:
    - op=0 with funct in {20,21,22,23,24,25,00,2A,2B}h -> EXEC_R.
    - op=08h -> EXEC_I.
    - op=23h/2Bh -> MEM_ADDR.
    - op=04h/05h/07h -> BRANCH.
    - Anything else -> TRAP, err_code=1.
- EXEC_R:
  - ALUSrcA=1, ALUSrcB=00.
  - ALUctr by funct: add=2, addu=4, sub=6, subu=6, and=0, or=1, sll=5, slt=3, sltu=7.
  - -> WB_ALU.
- WB_ALU: RegWr=1, RegDst=1, MemToReg=0; retire; -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUctr=2; -> WB_I.
- WB_I: RegWr=1, RegDst=0, MemToReg=0; retire; -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUctr=2; lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_req=1, IorD=1; on mem_ready -> WB_MEM.
- WB_MEM: RegWr=1, RegDst=0, MemToReg=1; retire; -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, IorD=1; on mem_ready retire and -> FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUctr=6; PCSrc=1.
  - PCWr (Mealy, same cycle) = beq&equal | bne&!equal | bgtz&!equal&!sign.
  - Retire; -> FETCH.
- Memory timeout:
  - Wait counter clears on entry to FETCH/MEM_RD/MEM_WR.
  - Increments each cycle without mem_ready.
  - When the counter equals MEM_TIMEOUT and mem_ready=0 -> TRAP, err_code=2.
  - mem_ready in that same cycle wins: normal completion, no trap.
- TRAP: all strobes 0, halted=1; holds until reset.
- Retire:
  - retired increments by 1 in the final cycle of each instruction.
  - Wraps modulo 2^RET_W.
  - No increment on trap.
- mem_we is never 1 without mem_req.
- PCWr and RegWr are never both 1.
- Reset mid-access:
  - Takes effect at the next edge from any state; mem_req drops in the following cycle.
  - An abandoned access produces no IRWr/RegWr.

Decomposition:
- Shared package:
  - ALUctr encoding constants.
  - Opcode/funct constants.
  - State enumeration: FETCH, DECODE, EXEC_R, EXEC_I, WB_I, WB_ALU, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, BRANCH, TRAP.
  - err_code values.
- One sub-module, mc_instr_decode: combinational op/funct -> instruction class, R-type ALUctr, and illegal flag.
- The FSM, wait counter and retire counter stay in multicycle_control.

Test Plan:
- add (op=0, funct=20h), mem_ready on the 1st FETCH cycle -> sequence FETCH, DECODE, EXEC_R (ALUctr=2), WB_ALU (RegWr=1, RegDst=1); retired=1 after 4 cycles.
- lw (op=23h), mem_ready after 3 wait cycles in both FETCH and MEM_RD -> IRWr single pulse; WB_MEM MemToReg=1; 11 cycles total.
- beq, equal=1 -> PCWr=1 and PCSrc=1 in BRANCH; repeat with equal=0 -> PCWr=0; bgtz with sign=1 -> not taken.
- op=3Fh -> TRAP after DECODE; halted=1, err_code=1; retired unchanged.
  - Further inputs ignored until reset.
  - reset then returns to FETCH with all outputs 0 except fetch strobes.
- sw with mem_ready held low, MEM_TIMEOUT=15 -> TRAP after 16 MEM_WR cycles with err_code=2.
  - Variant with mem_ready on cycle 16 -> no trap, retire.
- reset asserted while in MEM_RD -> next cycle state=FETCH, retired=0, no RegWr pulse.
  - Also: RET_W=4 with 16 sequential add instructions -> retired wraps to 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset sequencer: ALU operations,
// opcode/funct values, FSM states, instruction classes and trap causes.
package multicycle_control_pkg;

    // ALU operation select driven on ALUctr
    localparam logic [2:0] ALU_AND  = 3'd0;
    localparam logic [2:0] ALU_OR   = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;
    localparam logic [2:0] ALU_ADDU = 3'd4;
    localparam logic [2:0] ALU_SLL  = 3'd5;
    localparam logic [2:0] ALU_SUB  = 3'd6;
    localparam logic [2:0] ALU_SLTU = 3'd7;

    // ALU B operand select driven on ALUSrcB
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BGTZ  = 6'h07;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    // Trap cause reported on err_code
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // Width of the memory wait counter; covers timeouts up to 255 cycles
    localparam int WAIT_W = 8;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        WB_I,
        WB_ALU,
        MEM_ADDR,
        MEM_RD,
        MEM_WR,
        WB_MEM,
        BRANCH,
        TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_MEM,
        CLS_BR,
        CLS_ILL
    } instr_class_t;

endpackage

// File: rtl/multicycle_control_instr_decode.sv
// Combinational instruction classifier: maps op/funct to an instruction class,
// the ALU operation used by R-type execution, and an illegal-instruction flag.
module mc_instr_decode
    import multicycle_control_pkg::*;
(
    input  logic [5:0]   op_i,
    input  logic [5:0]   funct_i,
    output instr_class_t cls_o,
    output logic [2:0]   r_aluctr_o,
    output logic         illegal_o
);

    // Classify the opcode; unsupported R-type functs fall into the illegal class
    always_comb begin
        cls_o      = CLS_ILL;
        r_aluctr_o = ALU_AND;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    F_ADD:   begin cls_o = CLS_R; r_aluctr_o = ALU_ADD;  end
                    F_ADDU:  begin cls_o = CLS_R; r_aluctr_o = ALU_ADDU; end
                    F_SUB:   begin cls_o = CLS_R; r_aluctr_o = ALU_SUB;  end
                    F_SUBU:  begin cls_o = CLS_R; r_aluctr_o = ALU_SUB;  end
                    F_AND:   begin cls_o = CLS_R; r_aluctr_o = ALU_AND;  end
                    F_OR:    begin cls_o = CLS_R; r_aluctr_o = ALU_OR;   end
                    F_SLL:   begin cls_o = CLS_R; r_aluctr_o = ALU_SLL;  end
                    F_SLT:   begin cls_o = CLS_R; r_aluctr_o = ALU_SLT;  end
                    F_SLTU:  begin cls_o = CLS_R; r_aluctr_o = ALU_SLTU; end
                    default: cls_o = CLS_ILL;
                endcase
            end
            OP_ADDI:                  cls_o = CLS_I;
            OP_LW, OP_SW:             cls_o = CLS_MEM;
            OP_BEQ, OP_BNE, OP_BGTZ:  cls_o = CLS_BR;
            default:                  cls_o = CLS_ILL;
        endcase
    end

    assign illegal_o = (cls_o == CLS_ILL);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for a MIPS-subset CPU sharing one memory port
// between instruction fetch and data access. Drives datapath strobes per state,
// times out stalled memory accesses, counts retired instructions and traps.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int RET_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             equal,
    input  logic             sign,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             IorD,
    output logic             IRWr,
    output logic             PCWr,
    output logic             PCSrc,
    output logic             RegWr,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             ExtOp,
    output logic [2:0]       ALUctr,
    output logic             halted,
    output logic [1:0]       err_code,
    output logic [RET_W-1:0] retired
);

    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [RET_W-1:0]   retired_q, retired_d;
    logic [1:0]         err_q, err_d;
    logic               retire;
    logic               timed_out;
    logic               branch_taken;
    logic               waiting;

    instr_class_t       cls;
    logic [2:0]         r_aluctr;
    logic               illegal;

    mc_instr_decode u_decode (
        .op_i       (op),
        .funct_i    (funct),
        .cls_o      (cls),
        .r_aluctr_o (r_aluctr),
        .illegal_o  (illegal)
    );

    // A memory access gives up once the wait counter reaches the limit with no ready
    assign timed_out    = (wait_q == TIMEOUT_CNT) && !mem_ready;
    assign branch_taken = ((op == OP_BEQ)  &&  equal)
                        | ((op == OP_BNE)  && !equal)
                        | ((op == OP_BGTZ) && !equal && !sign);

    // Next-state and strobe decode; every strobe defaults low each cycle
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        retire   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        IorD     = 1'b0;
        IRWr     = 1'b0;
        PCWr     = 1'b0;
        PCSrc    = 1'b0;
        RegWr    = 1'b0;
        RegDst   = 1'b0;
        MemToReg = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_RT;
        ExtOp    = 1'b0;
        ALUctr   = ALU_AND;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = SRCB_FOUR;
                ALUctr  = ALU_ADDU;
                if (mem_ready) begin
                    IRWr    = 1'b1;
                    PCWr    = 1'b1;
                    state_d = DECODE;
                end else if (timed_out) begin
                    state_d = TRAP;
                    err_d   = ERR_TIMEOUT;
                end
            end
            DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                ExtOp   = 1'b1;
                ALUctr  = ALU_ADD;
                if (illegal) begin
                    state_d = TRAP;
                    err_d   = ERR_ILLEGAL;
                end else begin
                    case (cls)
                        CLS_R:   state_d = EXEC_R;
                        CLS_I:   state_d = EXEC_I;
                        CLS_MEM: state_d = MEM_ADDR;
                        CLS_BR:  state_d = BRANCH;
                        default: begin
                            state_d = TRAP;
                            err_d   = ERR_ILLEGAL;
                        end
                    endcase
                end
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_RT;
                ALUctr  = r_aluctr;
                state_d = WB_ALU;
            end
            WB_ALU: begin
                RegWr   = 1'b1;
                RegDst  = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ExtOp   = 1'b1;
                ALUctr  = ALU_ADD;
                state_d = WB_I;
            end
            WB_I: begin
                RegWr   = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ExtOp   = 1'b1;
                ALUctr  = ALU_ADD;
                state_d = (op == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_d = WB_MEM;
                end else if (timed_out) begin
                    state_d = TRAP;
                    err_d   = ERR_TIMEOUT;
                end
            end
            WB_MEM: begin
                RegWr    = 1'b1;
                MemToReg = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end else if (timed_out) begin
                    state_d = TRAP;
                    err_d   = ERR_TIMEOUT;
                end
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_RT;
                ALUctr  = ALU_SUB;
                PCSrc   = 1'b1;
                PCWr    = branch_taken;
                retire  = 1'b1;
                state_d = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Wait counter restarts on every state change and counts stalled memory cycles
    always_comb begin
        waiting = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
        wait_d  = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (waiting && !mem_ready) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // Retired count advances in the last cycle of each instruction and wraps
    always_comb begin
        retired_d = retired_q;
        if (retire) begin
            retired_d = retired_q + RET_W'(1);
        end
    end

    // State, wait counter, retire counter and trap cause registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            retired_q <= '0;
            err_q     <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            err_q     <= err_d;
        end
    end

    assign halted   = (state_q == TRAP);
    assign err_code = err_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control: walks each instruction class
// through its state sequence with hand-computed strobe vectors, and exercises
// memory timeouts, illegal-opcode traps, mid-access reset and counter wrap.
module tb_multicycle_control;

    // Strobe vector layout:
    // {mem_req, mem_we, IorD, IRWr, PCWr, PCSrc, RegWr, RegDst, MemToReg,
    //  ALUSrcA, ALUSrcB[1:0], ExtOp, ALUctr[2:0]}
    localparam logic [15:0] V_FETCH_WAIT = 16'h8014;
    localparam logic [15:0] V_FETCH_DONE = 16'h9814;
    localparam logic [15:0] V_DECODE     = 16'h003A;
    localparam logic [15:0] V_EXEC_R     = 16'h0040;
    localparam logic [15:0] V_WB_ALU     = 16'h0300;
    localparam logic [15:0] V_IMM_ADD    = 16'h006A;
    localparam logic [15:0] V_WB_I       = 16'h0200;
    localparam logic [15:0] V_MEM_RD     = 16'hA000;
    localparam logic [15:0] V_WB_MEM     = 16'h0280;
    localparam logic [15:0] V_MEM_WR     = 16'hE000;
    localparam logic [15:0] V_BR_NOT     = 16'h0446;
    localparam logic [15:0] V_BR_TAKEN   = 16'h0C46;
    localparam logic [15:0] V_TRAP       = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  curOp;
    logic [5:0]  curFunct;
    logic        equalIn;
    logic        signIn;
    logic        memReady;

    logic        memReq, memWe, iOrD, irWr, pcWr, pcSrc, regWr, regDst, memToReg, aluSrcA, extOp, halted;
    logic [1:0]  aluSrcB, errCode;
    logic [2:0]  aluCtr;
    logic [31:0] retired;

    logic        sMemReq, sMemWe, sIOrD, sIrWr, sPcWr, sPcSrc, sRegWr, sRegDst, sMemToReg, sAluSrcA, sExtOp, sHalted;
    logic [1:0]  sAluSrcB, sErrCode;
    logic [2:0]  sAluCtr;
    logic [3:0]  sRetired;

    logic [15:0] strobes;
    logic [15:0] strobesSmall;

    int passCount = 0;
    int failCount = 0;
    int totalCount = 0;
    int cycleCount = 0;
    logic [31:0] expRetired = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(15), .RET_W(32)) dut (
        .clk(clk), .reset(reset), .op(curOp), .funct(curFunct), .equal(equalIn), .sign(signIn),
        .mem_ready(memReady), .mem_req(memReq), .mem_we(memWe), .IorD(iOrD), .IRWr(irWr),
        .PCWr(pcWr), .PCSrc(pcSrc), .RegWr(regWr), .RegDst(regDst), .MemToReg(memToReg),
        .ALUSrcA(aluSrcA), .ALUSrcB(aluSrcB), .ExtOp(extOp), .ALUctr(aluCtr),
        .halted(halted), .err_code(errCode), .retired(retired)
    );

    multicycle_control #(.MEM_TIMEOUT(15), .RET_W(4)) dutSmall (
        .clk(clk), .reset(reset), .op(curOp), .funct(curFunct), .equal(equalIn), .sign(signIn),
        .mem_ready(memReady), .mem_req(sMemReq), .mem_we(sMemWe), .IorD(sIOrD), .IRWr(sIrWr),
        .PCWr(sPcWr), .PCSrc(sPcSrc), .RegWr(sRegWr), .RegDst(sRegDst), .MemToReg(sMemToReg),
        .ALUSrcA(sAluSrcA), .ALUSrcB(sAluSrcB), .ExtOp(sExtOp), .ALUctr(sAluCtr),
        .halted(sHalted), .err_code(sErrCode), .retired(sRetired)
    );

    assign strobes = {memReq, memWe, iOrD, irWr, pcWr, pcSrc, regWr, regDst, memToReg,
                      aluSrcA, aluSrcB, extOp, aluCtr};
    assign strobesSmall = {sMemReq, sMemWe, sIOrD, sIrWr, sPcWr, sPcSrc, sRegWr, sRegDst, sMemToReg,
                           sAluSrcA, sAluSrcB, sExtOp, sAluCtr};

    // Safety net so the run always ends even if the sequence stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cycleCount++;
    endtask

    task automatic applyStimulus(input logic ready, input logic eq, input logic sgn);
        memReady = ready;
        equalIn  = eq;
        signIn   = sgn;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkStrobes(input string tag, input logic [15:0] expected);
        checkOutput(tag, {16'h0, strobes}, {16'h0, expected});
        checkOutput({tag, "/small"}, {16'h0, strobesSmall}, {16'h0, expected});
    endtask

    task automatic checkRetired(input string tag);
        checkOutput({tag, "/retired"}, retired, expRetired);
        checkOutput({tag, "/retiredSmall"}, {28'h0, sRetired}, {28'h0, expRetired[3:0]});
    endtask

    task automatic doFetch(input int nWait);
        for (int i = 0; i < nWait; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkStrobes("fetchWait", V_FETCH_WAIT);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkStrobes("fetchDone", V_FETCH_DONE);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkStrobes("decode", V_DECODE);
        tick();
    endtask

    task automatic runR(input logic [5:0] functV, input logic [2:0] expCtl);
        curOp    = 6'h00;
        curFunct = functV;
        doFetch(0);
        checkStrobes("execR", V_EXEC_R | {13'h0, expCtl});
        tick();
        checkStrobes("wbAlu", V_WB_ALU);
        tick();
        expRetired++;
        checkRetired("rType");
    endtask

    task automatic runBranch(input logic [5:0] opV, input logic eq, input logic sgn, input logic taken);
        curOp    = opV;
        curFunct = 6'h00;
        doFetch(0);
        applyStimulus(1'b0, eq, sgn);
        checkStrobes("branch", taken ? V_BR_TAKEN : V_BR_NOT);
        tick();
        expRetired++;
        checkRetired("branch");
    endtask

    initial begin
        reset = 1'b1;
        curOp = 6'h00;
        curFunct = 6'h20;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkStrobes("resetFetch", V_FETCH_WAIT);
        checkRetired("reset");
        checkOutput("resetHalted", {31'h0, halted}, 32'h0);
        checkOutput("resetErr", {30'h0, errCode}, 32'h0);

        // add with immediate fetch completes in four cycles
        cycleCount = 0;
        runR(6'h20, 3'd2);
        checkOutput("addCycles", cycleCount, 32'd4);

        // lw with three wait cycles in fetch and in the data read
        curOp = 6'h23;
        cycleCount = 0;
        doFetch(3);
        checkStrobes("lwAddr", V_IMM_ADD);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkStrobes("lwRdWait", V_MEM_RD);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkStrobes("lwRdDone", V_MEM_RD);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkStrobes("wbMem", V_WB_MEM);
        tick();
        expRetired++;
        checkRetired("lw");
        checkOutput("lwCycles", cycleCount, 32'd11);

        // Other R-type ALU mappings
        runR(6'h22, 3'd6);
        runR(6'h23, 3'd6);
        runR(6'h00, 3'd5);
        runR(6'h2B, 3'd7);
        runR(6'h25, 3'd1);
        runR(6'h2A, 3'd3);

        // addi
        curOp = 6'h08;
        doFetch(0);
        checkStrobes("execI", V_IMM_ADD);
        tick();
        checkStrobes("wbI", V_WB_I);
        tick();
        expRetired++;
        checkRetired("addi");

        // Branch decisions
        runBranch(6'h04, 1'b1, 1'b0, 1'b1);
        runBranch(6'h04, 1'b0, 1'b0, 1'b0);
        runBranch(6'h05, 1'b0, 1'b0, 1'b1);
        runBranch(6'h05, 1'b1, 1'b0, 1'b0);
        runBranch(6'h07, 1'b0, 1'b1, 1'b0);
        runBranch(6'h07, 1'b0, 1'b0, 1'b1);
        runBranch(6'h07, 1'b1, 1'b0, 1'b0);

        // sw whose ready arrives on the last allowed wait cycle completes normally
        curOp = 6'h2B;
        doFetch(0);
        checkStrobes("swAddr", V_IMM_ADD);
        tick();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkStrobes("swWait", V_MEM_WR);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkStrobes("swLateReady", V_MEM_WR);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        expRetired++;
        checkRetired("swLate");
        checkOutput("swLateHalted", {31'h0, halted}, 32'h0);
        checkStrobes("swLateFetch", V_FETCH_WAIT);

        // Reset while waiting in MEM_RD abandons the load
        curOp = 6'h23;
        doFetch(0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkStrobes("rdBeforeReset", V_MEM_RD);
        tick();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkStrobes("rdDuringReset", V_MEM_RD);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        expRetired = 0;
        checkStrobes("afterMidReset", V_FETCH_WAIT);
        checkRetired("midReset");

        // Sixteen adds wrap the 4-bit counter back to zero
        for (int i = 0; i < 16; i++) begin
            runR(6'h20, 3'd2);
        end
        checkOutput("wrapSmall", {28'h0, sRetired}, 32'h0);
        checkOutput("wrapWide", retired, 32'd16);

        // sw with no ready traps on the sixteenth MEM_WR cycle
        curOp = 6'h2B;
        doFetch(0);
        tick();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkStrobes("swTimeoutWait", V_MEM_WR);
            tick();
        end
        checkStrobes("timeoutTrap", V_TRAP);
        checkOutput("timeoutHalted", {31'h0, halted}, 32'h1);
        checkOutput("timeoutErr", {30'h0, errCode}, 32'd2);
        checkOutput("timeoutErrSmall", {30'h0, sErrCode}, 32'd2);
        checkRetired("timeout");

        // Illegal opcode traps after decode and ignores later inputs
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expRetired = 0;
        curOp = 6'h3F;
        doFetch(0);
        checkStrobes("illegalTrap", V_TRAP);
        checkOutput("illegalHalted", {31'h0, halted}, 32'h1);
        checkOutput("illegalErr", {30'h0, errCode}, 32'd1);
        checkRetired("illegal");
        curOp = 6'h00;
        curFunct = 6'h20;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            checkStrobes("trapHold", V_TRAP);
            checkOutput("trapHoldHalted", {31'h0, sHalted}, 32'h1);
            tick();
        end
        checkOutput("trapHoldErr", {30'h0, errCode}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkStrobes("postTrapFetch", V_FETCH_WAIT);
        checkOutput("postTrapHalted", {31'h0, halted}, 32'h0);
        checkOutput("postTrapErr", {30'h0, errCode}, 32'h0);
        checkRetired("postTrap");

        $display("[TB] %0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
